// File: rtl/fnd_pkg.sv
// Shared constants and state encoding for the FND scan controller and its encoder.
package fnd_pkg;

    localparam logic [6:0] FND_BLANK = 7'h7F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/fnd_encoder.sv
// One-hot decimal digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module fnd_encoder
    import fnd_pkg::*;
(
    input  logic [9:0] onehot,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default first so every path assigns seg and no latch is inferred.
        seg = FND_BLANK;
        case (onehot)
            10'b00_0000_0001: seg = 7'h40;
            10'b00_0000_0010: seg = 7'h79;
            10'b00_0000_0100: seg = 7'h24;
            10'b00_0000_1000: seg = 7'h30;
            10'b00_0001_0000: seg = 7'h19;
            10'b00_0010_0000: seg = 7'h12;
            10'b00_0100_0000: seg = 7'h02;
            10'b00_1000_0000: seg = 7'h78;
            10'b01_0000_0000: seg = 7'h00;
            10'b10_0000_0000: seg = 7'h10;
            default:          seg = FND_BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed FND scan controller: double-buffered BCD digits, guard-blanked slots,
// one shared encoder driven from a registered one-hot code.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 500
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                    wr_data,
    input  logic                          commit,
    output logic                          commit_ack,
    output logic                          frame_done,
    output logic [NUM_DIGITS-1:0]         fnd_com,
    output logic [6:0]                    fnd_data
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int SLOT_W = $clog2(SCAN_DIV);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] LIT_END   = SLOT_W'(SCAN_DIV - GUARD);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    state_t            state, state_nxt;
    logic [SLOT_W-1:0] slot_cnt, slot_nxt;
    logic [IDX_W-1:0]  digit_idx, idx_nxt;
    logic              wrap;
    logic              lit;
    logic              pending;
    logic [9:0]        enc_in;

    logic [3:0] shadow     [NUM_DIGITS];
    logic [3:0] shadow_nxt [NUM_DIGITS];
    logic [3:0] active     [NUM_DIGITS];

    always_comb begin
        state_nxt = state;
        slot_nxt  = '0;
        idx_nxt   = '0;
        wrap      = 1'b0;
        case (state)
            IDLE: if (enable) state_nxt = SCAN;
            SCAN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (slot_cnt == SLOT_LAST) begin
                    wrap    = (digit_idx == IDX_LAST);
                    idx_nxt = wrap ? '0 : digit_idx + 1'b1;
                end else begin
                    slot_nxt = slot_cnt + 1'b1;
                    idx_nxt  = digit_idx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dropping enable darkens the very next output cycle, even mid-slot.
    assign lit = (state == SCAN) && enable && (slot_cnt < LIT_END);

    // A same-cycle write is folded in here so a coincident commit copies it.
    always_comb begin
        shadow_nxt = shadow;
        if (wr_en && (int'(wr_addr) < NUM_DIGITS)) shadow_nxt[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            digit_idx  <= '0;
            pending    <= 1'b0;
            commit_ack <= 1'b0;
            frame_done <= 1'b0;
            // NOTE: both banks are a handful of flops that must power up blank,
            // so they are reset here rather than left to a RAM.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= BCD_BLANK;
                active[i] <= BCD_BLANK;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nxt;
            slot_cnt   <= slot_nxt;
            digit_idx  <= idx_nxt;
            shadow     <= shadow_nxt;
            frame_done <= wrap;
            commit_ack <= 1'b0;
            if (wrap && (pending || commit)) begin
                active     <= shadow_nxt;
                pending    <= 1'b0;
                commit_ack <= 1'b1;
            end else if (commit) begin
                pending <= 1'b1;
            end
        end
    end

    // Output stage sees last cycle's counters and the pre-update active bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fnd_com <= '1;
            enc_in  <= '0;
        end else if (lit) begin
            fnd_com <= ~(NUM_DIGITS'(1) << digit_idx);
            enc_in  <= 10'b1 << active[digit_idx];
        end else begin
            fnd_com <= '1;
            enc_in  <= '0;
        end
    end

    fnd_encoder u_enc (
        .onehot (enc_in),
        .seg    (fnd_data)
    );

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
module tb_fnd_scan_ctrl;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int GD    = 2;
    localparam int FRAME = ND * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       commit_ack;
    logic       frame_done;
    logic [3:0] fnd_com;
    logic [6:0] fnd_data;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GUARD      (GD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .commit_ack (commit_ack),
        .frame_done (frame_done),
        .fnd_com    (fnd_com),
        .fnd_data   (fnd_data)
    );

    // Expected vector packs {com[3:0], data[6:0], ack, frame_done}.
    typedef struct {
        logic [12:0] vec;
        string       tag;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b0, 1'b0};

    // Reference state: phase 0 idle, 1 entering scan, 2 scanning; c = output cycle index.
    int         phase = 0;
    int         c = 0;
    string      tag = "init";
    bit         commit_out = 1'b0;
    logic [3:0] disp   [ND];
    logic [3:0] staged [ND];

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got com=%b data=%h ack=%b fd=%b, want com=%b data=%h ack=%b fd=%b",
                     name, got[12:9], got[8:2], got[1], got[0],
                     want[12:9], want[8:2], want[1], want[0]);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("%s c=%0d", mon_e.tag, mon_e.cyc),
                  {fnd_com, fnd_data, commit_ack, frame_done}, mon_e.vec);
        end
    end

    // One clock: predict the outputs visible after this edge, queue them, return at negedge.
    task automatic step();
        logic [3:0] com;
        logic [6:0] data;
        logic       ack;
        logic       fd;
        int         dig;
        exp_t       e;
        @(posedge clk);
        com  = 4'hF;
        data = 7'h7F;
        ack  = 1'b0;
        fd   = 1'b0;
        if (phase == 1) begin
            phase = 2;
            c     = -1;
        end else if (phase == 2) begin
            c++;
            dig = (c / SD) % ND;
            if (c % SD < SD - GD) begin
                com  = ~(4'b0001 << dig);
                data = seg_of(disp[dig]);
            end
            if (c % FRAME == FRAME - 1) begin
                fd = 1'b1;
                if (commit_out) begin
                    ack        = 1'b1;
                    disp       = staged;
                    commit_out = 1'b0;
                end
            end
        end
        e.vec = {com, data, ack, fd};
        e.tag = tag;
        e.cyc = c;
        exp_q.push_back(e);
        @(negedge clk);
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_frame_pos(input int m);
        for (int i = 0; i < 2 * FRAME && !(phase == 2 && c % FRAME == m); i++) step();
    endtask

    task automatic run_until_slot(input int m);
        for (int i = 0; i < 2 * SD && !(phase == 2 && c % SD == m); i++) step();
    endtask

    task automatic write_digit(input logic [1:0] a, input logic [3:0] d);
        wr_en      = 1'b1;
        wr_addr    = a;
        wr_data    = d;
        staged[a]  = d;
        step();
    endtask

    task automatic commit_pulse();
        commit     = 1'b1;
        commit_out = 1'b1;
        step();
    endtask

    task automatic model_reset();
        phase      = 0;
        commit_out = 1'b0;
        for (int i = 0; i < ND; i++) begin
            disp[i]   = 4'hF;
            staged[i] = 4'hF;
        end
    endtask

    initial begin
        model_reset();

        #12;
        check("reset_state", {fnd_com, fnd_data, commit_ack, frame_done}, DARK);
        @(negedge clk);
        rst_n = 1'b1;

        tag = "idle";
        run(3);

        tag = "scan_blank";
        enable = 1'b1;
        phase  = 1;
        run(70);

        tag = "load_1234";
        write_digit(2'd0, 4'd1);
        write_digit(2'd1, 4'd2);
        write_digit(2'd2, 4'd3);
        write_digit(2'd3, 4'd4);
        commit_pulse();
        run(70);

        tag = "wrap_commit";
        run_until_frame_pos(FRAME - 2);
        wr_en      = 1'b1;
        wr_addr    = 2'd2;
        wr_data    = 4'd8;
        staged[2]  = 4'd8;
        commit     = 1'b1;
        commit_out = 1'b1;
        step();
        run(40);

        tag = "triple_commit";
        run_until_frame_pos(2);
        commit_pulse();
        run(5);
        commit_pulse();
        run(5);
        commit_pulse();
        run(70);

        tag = "disable";
        run_until_slot(2);
        enable = 1'b0;
        phase  = 0;
        step();
        run(4);
        tag = "reenable";
        enable = 1'b1;
        phase  = 1;
        run(20);

        tag = "blank_code";
        write_digit(2'd1, 4'd12);
        commit_pulse();
        run(70);

        tag = "async_reset";
        run_until_slot(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_dark", {fnd_com, fnd_data, commit_ack, frame_done}, DARK);
        enable = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tag = "post_reset";
        enable = 1'b1;
        phase  = 1;
        run(70);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
